backend_data_responder: RTL and testbench
=========================================

BACKEND_DATA_RESPONDER -- requirements
Module: backend_data_responder

Interface
REQ-001 Clocking SHALL be: one clock; reset is asynchronous and active-low.
REQ-002 Parameter FEDWidth, default 64: data chunk width in bits.
REQ-003 Parameter FEORAMBChunks, default 8: chunks per block, power of two, at least 2.
REQ-004 Parameter AddrWidth, default 6: block address width; storage holds 2^AddrWidth blocks.
REQ-005 Parameter BECMDWidth, default 2: command width; encodings BECMD_Update, BECMD_Append, BECMD_Read and BECMD_ReadRmv per the shared backend command header.
REQ-006 Clock  in  1  rising-edge clock.
REQ-007 Reset  in  1  asynchronous active-low reset.
REQ-008 CommandValid  in  1  command offered.
REQ-009 CommandReady  out  1  command accepted this cycle when Valid is also high.
REQ-010 Command  in  BECMDWidth  backend command.
REQ-011 PAddr  in  AddrWidth  block address.
REQ-012 StoreDataValid  in  1  store chunk offered by the frontend.
REQ-013 StoreDataReady  out  1  store chunk accepted.
REQ-014 StoreData  in  FEDWidth  store chunk.
REQ-015 LoadDataValid  out  1  load chunk offered to the frontend.
REQ-016 LoadDataReady  in  1  frontend accepts the load chunk.
REQ-017 LoadData  out  FEDWidth  load chunk.

Function
REQ-018 The FSM SHALL have four states: IDLE, STORE, FETCH and LOAD; it resets to IDLE.
REQ-019 CommandReady SHALL be high only in IDLE, and it SHALL NOT depend combinationally on CommandValid.
REQ-020 On command acceptance, the block SHALL latch Command and PAddr and clear the chunk counter (log2(FEORAMBChunks) bits).
- Update or Append: go to STORE.
- Read or ReadRmv: go to FETCH.
REQ-021 StoreDataReady SHALL equal (state==STORE).
REQ-022 Each store transfer SHALL write StoreData to chunk index counter of the latched block, then increment the counter.
- The transfer at counter FEORAMBChunks-1 SHALL wrap the counter to 0 and return the FSM to IDLE.
REQ-023 FETCH SHALL last exactly one cycle: it issues a synchronous read of chunk 0, then the FSM goes to LOAD. The first LoadDataValid SHALL therefore rise 2 cycles after the acceptance edge.
REQ-024 In LOAD, LoadData SHALL come from a registered output and SHALL stay stable while LoadDataValid is high and LoadDataReady is low.
REQ-025 The next chunk SHALL be prefetched so that back-to-back transfers sustain one chunk per cycle when LoadDataReady is held high.
REQ-026 Chunks SHALL be delivered in ascending index, chunk 0 first.
- The transfer of chunk FEORAMBChunks-1 SHALL drop LoadDataValid on the next cycle and return the FSM to IDLE.
REQ-027 LoadDataValid SHALL be low in every state except LOAD.
REQ-028 StoreDataValid outside STORE SHALL be ignored and SHALL leave no state change.
REQ-029 A command issued to the same address immediately after a store SHALL observe the completed store data.

Reset
REQ-030 Asserting Reset SHALL set the following asynchronously, including mid-transfer:
- FSM to IDLE, counter to 0.
- CommandReady=0 while Reset is asserted; it goes to 1 on the first cycle after deassertion.
- StoreDataReady=0, LoadDataValid=0, LoadData=0.
REQ-031 Storage array contents SHALL NOT be reset. A store interrupted by reset leaves that block partially written.

Configuration
REQ-032 Macro BE_RESPONDER_VALID_TRACK_EN, when defined, SHALL add one valid flop per block, cleared by reset.
- A completed store sets the bit.
- A Read or ReadRmv of a block with a clear bit returns all-zero chunks.
- ReadRmv clears the bit on its final chunk transfer.
REQ-033 When BE_RESPONDER_VALID_TRACK_EN is undefined, reads SHALL return raw array contents, ReadRmv SHALL behave identically to Read, and no valid flops SHALL exist.

Verification
REQ-034 Update addr 3 with chunks 0x11..0x18, then Read addr 3 with Ready always high -> LoadData 0x11..0x18 on 8 consecutive cycles, first Valid 2 cycles after acceptance.
REQ-035 Read addr 3 with LoadDataReady toggling 1,0,0,1 -> each chunk held stable while stalled, no chunk lost or repeated, FSM in IDLE after chunk 7.
REQ-036 With BE_RESPONDER_VALID_TRACK_EN: ReadRmv addr 3, then Read addr 3 -> first returns 0x11..0x18, second returns eight 0x0 chunks.
REQ-037 Reset asserted after the 4th store chunk, then Read of the same address -> chunks 0..3 new, 4..7 old; with the macro defined, all zero.
REQ-038 StoreDataValid=1 while in IDLE, and CommandValid=1 while in LOAD -> neither is accepted, and the array and outputs are unchanged.

Source files
------------

// File: rtl/backend_data_responder.sv
// Backend data responder: stores FEORAMBChunks-chunk blocks written by the
// frontend and streams them back on read commands. The read path has two
// stages: a synchronous array read register followed by a registered output
// stage. The next chunk is prefetched into the array read register, so a
// burst sustains one chunk per cycle while LoadDataReady is held high.
// Optional feature macro: BE_RESPONDER_VALID_TRACK_EN adds one valid flag per
// block. Reads of a block whose flag is clear return zeros, and ReadRmv
// clears the flag on its final chunk transfer.
module backend_data_responder #(
    parameter int FEDWidth      = 64,
    parameter int FEORAMBChunks = 8,
    parameter int AddrWidth     = 6,
    parameter int BECMDWidth    = 2
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  CommandValid,
    output logic                  CommandReady,
    input  logic [BECMDWidth-1:0] Command,
    input  logic [AddrWidth-1:0]  PAddr,
    input  logic                  StoreDataValid,
    output logic                  StoreDataReady,
    input  logic [FEDWidth-1:0]   StoreData,
    output logic                  LoadDataValid,
    input  logic                  LoadDataReady,
    output logic [FEDWidth-1:0]   LoadData
);
    localparam int CntWidth  = $clog2(FEORAMBChunks);
    localparam int NumBlocks = 1 << AddrWidth;
    localparam int MemDepth  = NumBlocks * FEORAMBChunks;

    localparam logic [BECMDWidth-1:0] BECMD_Update  = BECMDWidth'(0);
    localparam logic [BECMDWidth-1:0] BECMD_Append  = BECMDWidth'(1);
    localparam logic [BECMDWidth-1:0] BECMD_Read    = BECMDWidth'(2);
    localparam logic [BECMDWidth-1:0] BECMD_ReadRmv = BECMDWidth'(3);
    localparam logic [CntWidth-1:0]   LastChunk     = CntWidth'(FEORAMBChunks - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STORE = 2'd1,
        ST_FETCH = 2'd2,
        ST_LOAD  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [AddrWidth-1:0]    addr_q, addr_d;
    logic [CntWidth-1:0]     cnt_q, cnt_d;
    logic                    issued_all_q, issued_all_d;
    logic                    rd_vld_q, rd_vld_d;
    logic                    rd_last_q, rd_last_d;
    logic                    load_valid_q, load_valid_d;
    logic                    load_last_q, load_last_d;
    logic [FEDWidth-1:0]     load_data_q, load_data_d;
    logic                    command_ready_q, command_ready_d;
    logic                    store_ready_q, store_ready_d;

    logic [FEDWidth-1:0]     mem_q [MemDepth];
    logic [FEDWidth-1:0]     rd_data_q;
    logic [AddrWidth+CntWidth-1:0] mem_idx_s;

    logic accept_s, store_xfer_s, store_last_s, load_xfer_s, load_done_s;
    logic move_s, rd_issue_s, blk_ok_s;

    // Handshake qualifiers; the ready flops already imply the matching state.
    assign accept_s     = CommandValid & command_ready_q;
    assign store_xfer_s = StoreDataValid & store_ready_q;
    assign store_last_s = store_xfer_s & (cnt_q == LastChunk);
    assign load_xfer_s  = load_valid_q & LoadDataReady;
    assign load_done_s  = load_xfer_s & load_last_q;
    assign move_s       = (state_q == ST_LOAD) & rd_vld_q & (~load_valid_q | LoadDataReady);
    assign rd_issue_s   = (state_q == ST_FETCH) |
                          ((state_q == ST_LOAD) & ~issued_all_q & (~rd_vld_q | move_s));
    assign mem_idx_s    = {addr_q, cnt_q};

`ifdef BE_RESPONDER_VALID_TRACK_EN
    logic [NumBlocks-1:0] blk_valid_q, blk_valid_d;
    logic                 rmv_q, rmv_d;

    assign blk_ok_s = blk_valid_q[addr_q];

    // Per-block valid flags: set by a completed store, cleared by a finished ReadRmv.
    always_comb begin
        blk_valid_d = blk_valid_q;
        rmv_d       = rmv_q;
        if (accept_s) begin
            rmv_d = (Command == BECMD_ReadRmv);
        end else begin
            rmv_d = rmv_q;
        end
        if (store_last_s) begin
            blk_valid_d[addr_q] = 1'b1;
        end else if (load_done_s && rmv_q) begin
            blk_valid_d[addr_q] = 1'b0;
        end else begin
            blk_valid_d = blk_valid_q;
        end
    end

    // Valid-flag registers, cleared by reset.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            blk_valid_q <= '0;
            rmv_q       <= 1'b0;
        end else begin
            blk_valid_q <= blk_valid_d;
            rmv_q       <= rmv_d;
        end
    end
`else
    assign blk_ok_s = 1'b1;
`endif

    // Next-state logic, the chunk counter and the two-stage read pipeline.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        issued_all_d = issued_all_q;
        rd_vld_d     = rd_vld_q;
        rd_last_d    = rd_last_q;
        load_valid_d = load_valid_q;
        load_last_d  = load_last_q;
        load_data_d  = load_data_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    addr_d       = PAddr;
                    cnt_d        = '0;
                    issued_all_d = 1'b0;
                    rd_vld_d     = 1'b0;
                    case (Command)
                        BECMD_Update, BECMD_Append: state_d = ST_STORE;
                        BECMD_Read, BECMD_ReadRmv:  state_d = ST_FETCH;
                        default:                    state_d = ST_IDLE;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_STORE: begin
                if (store_xfer_s) begin
                    cnt_d = cnt_q + CntWidth'(1);
                    if (cnt_q == LastChunk) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_STORE;
                    end
                end else begin
                    state_d = ST_STORE;
                end
            end
            ST_FETCH: state_d = ST_LOAD;
            ST_LOAD: begin
                if (load_done_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The array read register refills whenever it is empty or being drained.
        if (rd_issue_s) begin
            cnt_d        = cnt_q + CntWidth'(1);
            rd_vld_d     = 1'b1;
            rd_last_d    = (cnt_q == LastChunk);
            issued_all_d = (cnt_q == LastChunk);
        end else if (move_s) begin
            rd_vld_d = 1'b0;
        end else begin
            rd_vld_d = rd_vld_d;
        end

        // The output stage only changes when empty or accepted, so a stalled chunk holds.
        if (move_s) begin
            load_valid_d = 1'b1;
            load_last_d  = rd_last_q;
            load_data_d  = blk_ok_s ? rd_data_q : '0;
        end else if (load_xfer_s) begin
            load_valid_d = 1'b0;
        end else begin
            load_valid_d = load_valid_q;
        end
    end

    assign command_ready_d = (state_d == ST_IDLE);
    assign store_ready_d   = (state_d == ST_STORE);

    // State, control and output registers; the array is kept out of reset.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q         <= ST_IDLE;
            addr_q          <= '0;
            cnt_q           <= '0;
            issued_all_q    <= 1'b0;
            rd_vld_q        <= 1'b0;
            rd_last_q       <= 1'b0;
            load_valid_q    <= 1'b0;
            load_last_q     <= 1'b0;
            load_data_q     <= '0;
            command_ready_q <= 1'b0;
            store_ready_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            cnt_q           <= cnt_d;
            issued_all_q    <= issued_all_d;
            rd_vld_q        <= rd_vld_d;
            rd_last_q       <= rd_last_d;
            load_valid_q    <= load_valid_d;
            load_last_q     <= load_last_d;
            load_data_q     <= load_data_d;
            command_ready_q <= command_ready_d;
            store_ready_q   <= store_ready_d;
        end
    end

    // Storage array write port and synchronous read port; contents survive reset.
    always_ff @(posedge Clock) begin
        if (store_xfer_s) begin
            mem_q[mem_idx_s] <= StoreData;
        end
        if (rd_issue_s) begin
            rd_data_q <= mem_q[mem_idx_s];
        end
    end

    assign CommandReady   = command_ready_q;
    assign StoreDataReady = store_ready_q;
    assign LoadDataValid  = load_valid_q;
    assign LoadData       = load_data_q;
endmodule

// File: tb/tb_backend_data_responder.sv
// Directed testbench for backend_data_responder (default parameters).
// Expectations follow BE_RESPONDER_VALID_TRACK_EN when it is defined.
module tb_backend_data_responder;
    localparam logic [1:0] CMD_UPDATE  = 2'd0;
    localparam logic [1:0] CMD_APPEND  = 2'd1;
    localparam logic [1:0] CMD_READ    = 2'd2;
    localparam logic [1:0] CMD_READRMV = 2'd3;

    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    logic        CommandValid = 1'b0;
    logic        CommandReady;
    logic [1:0]  Command = 2'd0;
    logic [5:0]  PAddr = 6'd0;
    logic        StoreDataValid = 1'b0;
    logic        StoreDataReady;
    logic [63:0] StoreData = 64'd0;
    logic        LoadDataValid;
    logic        LoadDataReady = 1'b0;
    logic [63:0] LoadData;

    int passed = 0;
    int total  = 0;
    logic [63:0] exp_q [8];

    backend_data_responder dut (
        .Clock(clk), .Reset(Reset),
        .CommandValid(CommandValid), .CommandReady(CommandReady),
        .Command(Command), .PAddr(PAddr),
        .StoreDataValid(StoreDataValid), .StoreDataReady(StoreDataReady),
        .StoreData(StoreData),
        .LoadDataValid(LoadDataValid), .LoadDataReady(LoadDataReady),
        .LoadData(LoadData)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic set_exp(input logic [63:0] base);
        for (int i = 0; i < 8; i++) exp_q[i] = base + 64'(i);
    endtask

    task automatic apply_reset(input string tag);
        Reset = 1'b0;
        #1;
        check({tag, "_rst_cmd_ready"}, {63'd0, CommandReady}, 64'd0);
        check({tag, "_rst_store_ready"}, {63'd0, StoreDataReady}, 64'd0);
        check({tag, "_rst_load_valid"}, {63'd0, LoadDataValid}, 64'd0);
        check({tag, "_rst_load_data"}, LoadData, 64'd0);
        @(negedge clk);
        @(negedge clk);
        Reset = 1'b1;
        #1;
        check({tag, "_cmd_ready_after_release"}, {63'd0, CommandReady}, 64'd0);
        @(negedge clk);
        check({tag, "_cmd_ready_first_cycle"}, {63'd0, CommandReady}, 64'd1);
    endtask

    task automatic store_blk(input string tag, input logic [5:0] a, input logic [1:0] cmd,
                             input logic [63:0] base, input int n);
        check({tag, "_cmd_ready"}, {63'd0, CommandReady}, 64'd1);
        CommandValid = 1'b1; Command = cmd; PAddr = a;
        @(negedge clk);
        CommandValid = 1'b0;
        check({tag, "_store_ready"}, {63'd0, StoreDataReady}, 64'd1);
        for (int i = 0; i < n; i++) begin
            StoreDataValid = 1'b1;
            StoreData = base + 64'(i);
            @(negedge clk);
        end
        StoreDataValid = 1'b0;
        if (n == 8) begin
            check({tag, "_store_ready_done"}, {63'd0, StoreDataReady}, 64'd0);
            check({tag, "_idle_after_store"}, {63'd0, CommandReady}, 64'd1);
        end
    endtask

    // pat[k] is LoadDataReady k cycles after acceptance (modulo 4).
    task automatic read_blk(input string tag, input logic [5:0] a, input logic [1:0] cmd,
                            input logic [3:0] pat, input bit hold_cmd);
        int cyc;
        int idx;
        int first;
        cyc = 0; idx = 0; first = -1;
        check({tag, "_cmd_ready"}, {63'd0, CommandReady}, 64'd1);
        CommandValid = 1'b1; Command = cmd; PAddr = a;
        @(negedge clk);
        CommandValid = hold_cmd;
        Command = CMD_UPDATE;
        while (idx < 8 && cyc < 40) begin
            if (LoadDataValid === 1'b1) begin
                if (first < 0) first = cyc;
                check($sformatf("%s_chunk%0d", tag, idx), LoadData, exp_q[idx]);
            end
            if (hold_cmd) check({tag, "_cmd_blocked"}, {63'd0, CommandReady}, 64'd0);
            LoadDataReady = pat[cyc % 4];
            if (LoadDataValid === 1'b1 && LoadDataReady === 1'b1) idx++;
            @(negedge clk);
            cyc++;
        end
        CommandValid = 1'b0;
        LoadDataReady = 1'b0;
        check({tag, "_all_chunks"}, 64'(idx), 64'd8);
        check({tag, "_first_valid_latency"}, 64'(first), 64'd2);
        if (pat == 4'b1111) check({tag, "_burst_cycles"}, 64'(cyc), 64'd10);
        check({tag, "_valid_drop"}, {63'd0, LoadDataValid}, 64'd0);
        check({tag, "_idle_after_load"}, {63'd0, CommandReady}, 64'd1);
    endtask

    initial begin
        @(negedge clk);
        apply_reset("init");

        // Update then immediate Read with Ready held high.
        store_blk("upd3", 6'd3, CMD_UPDATE, 64'h11, 8);
        set_exp(64'h11);
        read_blk("rd_burst", 6'd3, CMD_READ, 4'b1111, 1'b0);

        // Read with LoadDataReady toggling 1,0,0,1.
        read_blk("rd_stall", 6'd3, CMD_READ, 4'b1001, 1'b0);

        // Store data while idle must be ignored.
        StoreDataValid = 1'b1;
        StoreData = 64'hDEAD;
        @(negedge clk);
        @(negedge clk);
        check("idle_store_ready", {63'd0, StoreDataReady}, 64'd0);
        check("idle_cmd_ready", {63'd0, CommandReady}, 64'd1);
        check("idle_load_valid", {63'd0, LoadDataValid}, 64'd0);
        StoreDataValid = 1'b0;

        // Command held valid during the load must not be accepted; array unchanged.
        read_blk("rd_holdcmd", 6'd3, CMD_READ, 4'b1111, 1'b1);
        check("holdcmd_store_ready", {63'd0, StoreDataReady}, 64'd0);

        // Append to another block, then read it.
        store_blk("app9", 6'd9, CMD_APPEND, 64'hA0, 8);
        set_exp(64'hA0);
        read_blk("rd9", 6'd9, CMD_READ, 4'b1011, 1'b0);

        // ReadRmv then Read of the same block.
        set_exp(64'h11);
        read_blk("rmv3", 6'd3, CMD_READRMV, 4'b1111, 1'b0);
`ifdef BE_RESPONDER_VALID_TRACK_EN
        set_exp(64'h0);
        for (int i = 0; i < 8; i++) exp_q[i] = 64'h0;
`endif
        read_blk("rd_after_rmv", 6'd3, CMD_READ, 4'b1111, 1'b0);

        // Store interrupted by reset after four chunks.
        store_blk("intr9", 6'd9, CMD_UPDATE, 64'h21, 4);
        apply_reset("mid_store");
`ifdef BE_RESPONDER_VALID_TRACK_EN
        for (int i = 0; i < 8; i++) exp_q[i] = 64'h0;
`else
        for (int i = 0; i < 8; i++) exp_q[i] = (i < 4) ? 64'h21 + 64'(i) : 64'hA0 + 64'(i);
`endif
        read_blk("rd_partial", 6'd9, CMD_READ, 4'b1111, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
